// File: rtl/req_rr_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// req_rr_arbiter_pkg : shared state encoding and default sizing for the arbiter
// Revision: 1.0
// ============================================================================
package req_rr_arbiter_pkg;

   localparam int DEF_N       = 15;
   localparam int DEF_IDW     = 4;
   localparam int DEF_TIMEOUT = 16;
   localparam int ENC_W       = 15;
   localparam int ENC_IDW     = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/req_rr_arbiter_lsb_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rr_lsb_encoder : 15-bit lowest-index-first encoder with found flag
// Revision: 1.0
// ============================================================================
module rr_lsb_encoder
   import req_rr_arbiter_pkg::*;
(
   input  logic [ENC_W-1:0]   vec,
   output logic [ENC_IDW-1:0] idx,
   output logic               found
);

   // Scanning downward lets the lowest set bit overwrite the result last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = ENC_W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = ENC_IDW'(i);
            found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/req_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// req_rr_arbiter : round-robin arbiter with grant hold, release and timeout
// Revision: 1.0
// ============================================================================
module req_rr_arbiter
   import req_rr_arbiter_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int IDW     = DEF_IDW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           grant_valid,
   output logic           timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [CW-1:0]    hold, hold_nxt;
   logic [N-1:0]     grant_nxt;
   logic [IDW-1:0]   grant_id_nxt;
   logic             grant_valid_nxt;
   logic             timeout_err_nxt;

   logic [ENC_W-1:0]   req_ext, masked_ext;
   logic [ENC_IDW-1:0] idx_m, idx_u, win;
   logic               found_m, found_u;
   logic               owner_req, hold_max;

   // Requests below ptr are hidden so the search starts at the pointer.
   always_comb begin
      req_ext    = '0;
      masked_ext = '0;
      for (int i = 0; i < N; i++) begin
         req_ext[i]    = req[i];
         masked_ext[i] = req[i] && (i >= int'(ptr));
      end
   end

   rr_lsb_encoder u_enc_masked (
      .vec   (masked_ext),
      .idx   (idx_m),
      .found (found_m)
   );

   rr_lsb_encoder u_enc_unmasked (
      .vec   (req_ext),
      .idx   (idx_u),
      .found (found_u)
   );

   assign win       = found_m ? idx_m : idx_u;
   assign owner_req = |(req & grant);
   assign hold_max  = (hold == CW'(TIMEOUT));

   always_comb begin
      state_nxt       = state;
      ptr_nxt         = ptr;
      hold_nxt        = hold;
      grant_nxt       = grant;
      grant_id_nxt    = grant_id;
      grant_valid_nxt = grant_valid;
      timeout_err_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found_u) begin
               state_nxt       = ST_GRANT;
               grant_nxt       = N'(1) << win;
               grant_id_nxt    = IDW'(win);
               grant_valid_nxt = 1'b1;
               hold_nxt        = CW'(1);
            end
         end
         ST_GRANT: begin
            if (done || !owner_req || hold_max) begin
               state_nxt       = ST_IDLE;
               grant_nxt       = '0;
               grant_id_nxt    = '0;
               grant_valid_nxt = 1'b0;
               hold_nxt        = '0;
               ptr_nxt         = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
               // Only a pure timeout is an error; a coincident release is normal.
               timeout_err_nxt = !done && owner_req;
            end else if (!hold_max) begin
               hold_nxt = hold + CW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         hold        <= '0;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         hold        <= hold_nxt;
         grant       <= grant_nxt;
         grant_id    <= grant_id_nxt;
         grant_valid <= grant_valid_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_req_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_req_rr_arbiter : directed scoreboard bench for req_rr_arbiter
// Revision: 1.0
// ============================================================================
module tb_req_rr_arbiter;

   localparam int N       = 15;
   localparam int IDW     = 4;
   localparam int TIMEOUT = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           done;
   logic [N-1:0]   req;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic           grant_valid;
   logic           timeout_err;

   always #5 clk = ~clk;

   req_rr_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout_err (timeout_err)
   );

   typedef struct packed {
      logic       is_to;
      logic [3:0] id;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  prev_valid = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_grant(input int id);
      exp_q.push_back('{is_to: 1'b0, id: 4'(id)});
   endtask

   task automatic exp_timeout(input int id);
      exp_q.push_back('{is_to: 1'b1, id: 4'(id)});
   endtask

   task automatic rel(input string nm);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk({nm, "_idle"}, 32'(grant_valid), 0);
   endtask

   // Monitor: every new grant and every timeout pulse consumes one scoreboard entry.
   always @(negedge clk) begin : mon
      ev_t e;
      if (grant_valid === 1'b1 && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_grant: unexpected grant to %0d, none required", grant_id);
         end else begin
            e = exp_q.pop_front();
            chk("mon_grant_kind", 32'(e.is_to), 0);
            chk("mon_grant_id", 32'(grant_id), 32'(e.id));
            chk("mon_grant_vec", 32'(grant), 32'(1) << e.id);
         end
      end
      if (timeout_err === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_timeout: unexpected timeout_err, none required");
         end else begin
            e = exp_q.pop_front();
            chk("mon_timeout_kind", 32'(e.is_to), 1);
         end
      end
      prev_valid = (grant_valid === 1'b1);
   end

   initial begin
      int cnt;
      logic [N-1:0] rot_ids [4];
      logic [N-1:0] noise [4];
      rot_ids = '{15'd0, 15'd2, 15'd4, 15'd0};
      noise   = '{15'h0005, 15'h0204, 15'h0205, 15'h0004};

      reset = 1'b1;
      done  = 1'b0;
      req   = '0;
      repeat (3) cyc();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_grant_valid", 32'(grant_valid), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
      reset = 1'b0;

      // Reset mid-grant
      req = 15'h0008;
      exp_grant(3);
      cyc();
      chk("rstmid_pre_id", 32'(grant_id), 3);
      chk("rstmid_pre_valid", 32'(grant_valid), 1);
      reset = 1'b1;
      cyc();
      chk("rstmid_grant", 32'(grant), 0);
      chk("rstmid_valid", 32'(grant_valid), 0);
      chk("rstmid_id", 32'(grant_id), 0);
      reset = 1'b0;
      exp_grant(3);
      cyc();
      chk("rstmid_regrant_id", 32'(grant_id), 3);
      req = '0;
      cyc();
      chk("rstmid_withdraw", 32'(grant_valid), 0);

      // Rotation from ptr 0
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      req = 15'h0015;
      for (int k = 0; k < 4; k++) begin
         exp_grant(int'(rot_ids[k]));
         cyc();
         chk("rot_id", 32'(grant_id), 32'(rot_ids[k]));
         rel("rot");
      end

      // Wrap-around through 13, 14, 0
      req = 15'h2000;
      exp_grant(13);
      cyc();
      chk("wrap_id13", 32'(grant_id), 13);
      rel("wrap13");
      req = 15'h4001;
      exp_grant(14);
      cyc();
      chk("wrap_id14", 32'(grant_id), 14);
      rel("wrap14");
      exp_grant(0);
      cyc();
      chk("wrap_id0", 32'(grant_id), 0);
      rel("wrap0");

      // Withdrawal advances ptr past the owner
      req = 15'h0020;
      exp_grant(5);
      cyc();
      chk("wd_id", 32'(grant_id), 5);
      req = '0;
      cyc();
      chk("wd_valid", 32'(grant_valid), 0);
      chk("wd_no_err", 32'(timeout_err), 0);
      req = 15'h0060;
      exp_grant(6);
      cyc();
      chk("wd_ptr6", 32'(grant_id), 6);
      rel("wd6");

      // Timeout with req held and done low
      req = 15'h0080;
      exp_grant(7);
      cyc();
      chk("to_id", 32'(grant_id), 7);
      exp_timeout(7);
      cnt = 1;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (grant_valid !== 1'b1) break;
         cnt++;
      end
      chk("to_hold_cycles", 32'(cnt), TIMEOUT);
      chk("to_err_pulse", 32'(timeout_err), 1);
      req = '0;
      cyc();
      chk("to_err_single", 32'(timeout_err), 0);
      chk("to_stay_idle", 32'(grant_valid), 0);

      // done on the final hold cycle is a normal release
      req = 15'h0080;
      exp_grant(7);
      cyc();
      chk("to2_id", 32'(grant_id), 7);
      repeat (TIMEOUT - 1) cyc();
      chk("to2_still_held", 32'(grant_valid), 1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      req = '0;
      chk("to2_released", 32'(grant_valid), 0);
      chk("to2_no_err", 32'(timeout_err), 0);
      cyc();
      chk("to2_no_err_late", 32'(timeout_err), 0);

      // Non-owner noise and stray done in IDLE
      req = 15'h0004;
      exp_grant(2);
      cyc();
      chk("noise_id", 32'(grant_id), 2);
      for (int k = 0; k < 4; k++) begin
         req = noise[k];
         cyc();
         chk("noise_hold_id", 32'(grant_id), 2);
         chk("noise_hold_valid", 32'(grant_valid), 1);
      end
      req  = '0;
      rel("noise_rel");
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk("stray_done_valid", 32'(grant_valid), 0);
      chk("stray_done_err", 32'(timeout_err), 0);
      req = 15'h0201;
      exp_grant(9);
      cyc();
      chk("noise_next_id", 32'(grant_id), 9);
      req = '0;
      rel("noise9");

      repeat (3) cyc();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/req_rr_arbiter.md
# req_rr_arbiter

Round-robin arbiter that shares one resource among 15 requesters and holds each grant until the owner releases it, withdraws its request, or overruns a hold timeout. It sits in front of the shared datapath, and the 15-bit request vector has the same layout as the team's 15-input priority encoder. The block reuses that lowest-index-first encoding internally and adds a rotating priority pointer and a grant-holding state machine.

## Interface
Parameters:
- N, 15, number of requesters (2..15)
- IDW, 4, width of grant_id (ceil(log2 N), at least 1)
- TIMEOUT, 16, maximum cycles a grant may be held (≥2)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N  request per requester, level-sensitive; bit i = requester i
- done  input  1  owner releases the grant; honoured only in GRANT state
- grant  output  N  one-hot grant, registered; all-zero when idle
- grant_id  output  IDW  index of the granted requester, registered; 0 when idle
- grant_valid  output  1  high while any grant is held, registered
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- Two-state FSM.
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- Reset:
  - state goes to IDLE and ptr to 0.
  - grant=0, grant_id=0, grant_valid=0, timeout_err=0, hold counter=0.
  - Reset asserted mid-grant clears the grant at that edge. Partial hold counts are discarded.
- Arbitration, evaluated in IDLE only:
  - masked = req & ~((1<<ptr)-1), i.e. bits at or above ptr.
  - If masked is nonzero, the winner is its lowest set index. Otherwise the winner is the lowest set index of req.
  - If req is zero, remain in IDLE.
  - On a winner w, next edge: state=GRANT, grant=1<<w, grant_id=w, grant_valid=1, hold counter=1.
- GRANT state:
  - The hold counter increments each cycle, saturating at TIMEOUT.
  - Release conditions, checked in priority order on the same edge:
    - (a) done=1
    - (b) req[grant_id]=0, meaning the request was withdrawn
    - (c) hold counter == TIMEOUT
  - Any release returns the FSM to IDLE at the next edge and clears grant, grant_id and grant_valid.
  - On release, ptr = grant_id+1, wrapping to 0 when grant_id == N-1.
  - timeout_err pulses for exactly one cycle, aligned with the IDLE cycle, only when (c) is the sole cause. If (a) or (b) coincides with (c), release is normal and there is no error pulse.
- Changes on req to non-owner bits during GRANT are ignored. There is no preemption.
- done asserted while in IDLE is ignored.
- Requests in bits ≥ N do not exist. The internal encoder input is zero-extended to 15 bits.

## Timing
- Arbitration latency: req sampled at edge k while IDLE gives grant visible after edge k, so the requester sees the grant one cycle after asserting.
- Release latency: done sampled at edge k clears grant after edge k.
- Every release forces at least one IDLE cycle. Minimum grant-to-grant spacing is therefore 2 cycles, and one requester cannot hold the resource back-to-back if others are requesting.
- Maximum hold is TIMEOUT cycles of grant_valid=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/header holds:
  - the state encodings IDLE=1'b0 and GRANT=1'b1
  - default values of N, IDW and TIMEOUT
- Natural sub-module: rr_lsb_encoder. It is a combinational 15-bit lowest-index encoder with a found flag, instantiated twice (masked and unmasked vectors).
- The top level owns the FSM, ptr register, hold counter and output registers.
- Hold counter width is ceil(log2(TIMEOUT+1)).

## Test plan
- Reset mid-grant: grant requester 3, assert reset for 1 cycle. After that edge, grant=0, grant_valid=0, grant_id=0. After reset releases with req=15'h0008, grant_id=3 one cycle later.
- Rotation: req=15'h0015 (bits 0, 2, 4) held, done pulsed each grant. grant_id sequence is 0, 2, 4, 0, with one IDLE cycle between grants.
- Wrap-around: ptr=14 after a grant to 13, req=15'h4001. Grant goes to 14, then to 0 after release; the ptr wrap is checked.
- Withdrawal: grant requester 5, then drop req[5] with done=0. grant_valid falls at the next edge, timeout_err stays 0, and ptr becomes 6.
- Timeout: TIMEOUT=16, requester 7 holds req with done=0. grant_valid is high for exactly 16 cycles, then timeout_err=1 for 1 cycle. With done=1 on the 16th cycle instead, there is no timeout_err pulse.
- Non-owner noise: while 2 is granted, toggle req bits 0/9 and pulse done in IDLE. There is no grant change until 2 releases. The stray done in IDLE has no effect.
